// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/response bundle between execute-stage control and the ALU/MDU
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             m_op;
    logic [3:0]       alu_ctrl;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output start, m_op, alu_ctrl, funct3, a, b,
        input  ready, busy, done, result, zero
    );

    modport slave (
        input  start, m_op, alu_ctrl, funct3, a, b,
        output ready, busy, done, result, zero
    );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle base ALU plus iterative RV32M multiply/divide behind start/ready/done
module alu_mdu #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      reset_n,
    alu_mdu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_n;
    logic [SHW-1:0] cnt, sh;
    logic [1:0] f3;
    logic an, bn, accept, last, mul_op, div_fast, a_sg, b_sg, a_neg, b_neg;
    logic [WIDTH-1:0] opnd, ma, mb, alu_res, fast_res, m_res, q, r;
    logic [2*WIDTH-1:0] acc, acc_n, mul_n, div_n, prod;
    logic [WIDTH:0] sum, shd, diff;

    function automatic logic cond(input logic [WIDTH-1:0] v, input logic [2:0] f);
        return (f == 3'b000 || f == 3'b101 || f == 3'b111) ? v == '0 :
               (f == 3'b100 || f == 3'b110) ? v == WIDTH'(1) : f == 3'b001 && v != '0;
    endfunction

    assign bus.ready = state == IDLE || state == DONE;
    assign bus.busy = state == MUL || state == DIV;
    assign bus.done = state == DONE;
    assign accept = bus.start && bus.ready;
    assign last = cnt == SHW'(WIDTH - 1);
    assign sh = bus.b[SHW-1:0];
    assign mul_op = bus.m_op && !bus.funct3[2];
    assign div_fast = bus.b == '0 ||
                      (!bus.funct3[0] && bus.a == {1'b1, {(WIDTH-1){1'b0}}} && bus.b == '1);
    assign fast_res = bus.b == '0 ? (bus.funct3[1] ? bus.a : '1) : (bus.funct3[1] ? '0 : bus.a);

    // Signedness per op: DIV/REM both signed; MULH both; MULHSU only a
    assign a_sg = bus.funct3[2] ? !bus.funct3[0] : (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10);
    assign b_sg = bus.funct3[2] ? !bus.funct3[0] : bus.funct3[1:0] == 2'b01;
    assign a_neg = a_sg && bus.a[WIDTH-1];
    assign b_neg = b_sg && bus.b[WIDTH-1];
    assign ma = a_neg ? -bus.a : bus.a;
    assign mb = b_neg ? -bus.b : bus.b;

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_n = {sum, acc[WIDTH-1:1]};
    assign shd = acc[2*WIDTH-1:WIDTH-1];
    assign diff = shd - {1'b0, opnd};
    assign div_n = diff[WIDTH] ? {shd[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign acc_n = state == MUL ? mul_n : div_n;
    assign prod = (an ^ bn) ? -mul_n : mul_n;
    assign q = (an ^ bn) ? -div_n[WIDTH-1:0] : div_n[WIDTH-1:0];
    assign r = an ? -div_n[2*WIDTH-1:WIDTH] : div_n[2*WIDTH-1:WIDTH];
    assign m_res = state == MUL ? (f3 == 2'b00 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]) : (f3[1] ? r : q);

    always_comb begin
        alu_res = '0;
        case (bus.alu_ctrl)
            4'b0000: alu_res = bus.a + bus.b;
            4'b0001: alu_res = bus.a - bus.b;
            4'b0010: alu_res = bus.a & bus.b;
            4'b0011: alu_res = bus.a | bus.b;
            4'b0100: alu_res = bus.a ^ bus.b;
            4'b0101: alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            4'b1001: alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            4'b0110: alu_res = bus.a << sh;
            4'b1000: alu_res = bus.a >> sh;
            4'b0111: alu_res = $signed(bus.a) >>> sh;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        if (bus.ready) state_n = !bus.start ? IDLE : mul_op ? MUL :
                                 (bus.m_op && !div_fast) ? DIV : DONE;
        else if (last) state_n = DONE;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            bus.result <= '0;
            bus.zero <= 1'b0;
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
            if (!bus.m_op) begin
                bus.result <= alu_res;
                bus.zero <= cond(alu_res, bus.funct3);
            end else if (state_n == DONE) begin
                bus.result <= fast_res;
                bus.zero <= 1'b0;
            end
        end else if (bus.busy) begin
            cnt <= cnt + 1'b1;
            if (last) begin
                bus.result <= m_res;
                bus.zero <= 1'b0;
            end
        end

    always_ff @(posedge clk)
        if (accept) begin
            f3 <= bus.funct3[1:0];
            an <= a_neg;
            bn <= b_neg;
            opnd <= mul_op ? ma : mb;
            acc <= {{WIDTH{1'b0}}, mul_op ? mb : ma};
        end else if (bus.busy) begin
            acc <= acc_n;
        end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: randomized and directed checks of alu_mdu against a plain-arithmetic reference model
module tb_alu_mdu;
    localparam int W = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;

    typedef struct {
        logic m; logic [3:0] c; logic [2:0] f;
        logic [31:0] a; logic [31:0] b; logic [31:0] r; logic z; int lat; int bc;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    alu_mdu_if #(.WIDTH(W)) bus ();
    alu_mdu #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(input logic m, input logic [3:0] c, input logic [2:0] f,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        logic ovf = a == MIN && b == 32'hFFFF_FFFF;
        if (!m) begin
            case (c)
                4'd0: return a + b;
                4'd1: return a - b;
                4'd2: return a & b;
                4'd3: return a | b;
                4'd4: return a ^ b;
                4'd5: return {31'b0, sa < sb};
                4'd9: return {31'b0, {32'b0, a} < ub};
                4'd6: return a << b[4:0];
                4'd8: return a >> b[4:0];
                4'd7: return 32'(sa >>> b[4:0]);
                default: return 32'd0;
            endcase
        end
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: return b == 0 ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    function automatic logic ref_zero(input logic m, input logic [2:0] f, input logic [31:0] v);
        if (m) return 1'b0;
        case (f)
            3'd0, 3'd5, 3'd7: return v == 0;
            3'd1: return v != 0;
            3'd4, 3'd6: return v == 1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int ref_lat(input logic m, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!m) return 1;
        if (!f[2]) return W + 1;
        if (b == 0 || (!f[0] && a == MIN && b == 32'hFFFF_FFFF)) return 1;
        return W + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MIN;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op from an aligned point (#1 after a rising edge); returns observed result and timing
    task automatic run_op(input logic m, input logic [3:0] c, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output int lat, output int bc);
        bus.m_op = m; bus.alu_ctrl = c; bus.funct3 = f; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        bc = 0;
        do begin
            @(negedge clk);
            lat++;
            if (bus.busy) bc++;
        end while (!bus.done && lat < 100);
        res = bus.result;
        z = bus.zero;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL reset ready: got %b want 1", bus.ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b want 0", bus.done); end
        n_cmp++; if (bus.result !== 32'd0) begin n_bad++; $display("FAIL reset result: got %h want 0", bus.result); end
        n_cmp++; if (bus.zero !== 1'b0) begin n_bad++; $display("FAIL reset zero: got %b want 0", bus.zero); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_base;
        vec_t t[8] = '{
            '{1'b0, 4'd0, 3'd2, 32'd5, 32'd7, 32'd12, 1'b0, 1, 0},
            '{1'b0, 4'd1, 3'd0, 32'd3, 32'd3, 32'd0, 1'b1, 1, 0},
            '{1'b0, 4'd7, 3'd1, MIN, 32'd4, 32'hF800_0000, 1'b1, 1, 0},
            '{1'b0, 4'd5, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1, 0},
            '{1'b0, 4'd9, 3'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1, 0},
            '{1'b0, 4'd6, 3'd7, 32'd1, 32'd31, MIN, 1'b0, 1, 0},
            '{1'b0, 4'd8, 3'd6, MIN, 32'd31, 32'd1, 1'b1, 1, 0},
            '{1'b0, 4'd15, 3'd0, 32'd5, 32'd6, 32'd0, 1'b1, 1, 0}};
        logic [31:0] res; logic z; int lat, bc;
        foreach (t[i]) begin
            run_op(t[i].m, t[i].c, t[i].f, t[i].a, t[i].b, res, z, lat, bc);
            n_cmp++; if (res !== t[i].r) begin n_bad++; $display("FAIL base[%0d] result: got %h want %h", i, res, t[i].r); end
            n_cmp++; if (z !== t[i].z) begin n_bad++; $display("FAIL base[%0d] zero: got %b want %b", i, z, t[i].z); end
            n_cmp++; if (lat != t[i].lat) begin n_bad++; $display("FAIL base[%0d] latency: got %0d want %0d", i, lat, t[i].lat); end
        end
    endtask

    task automatic test_mul;
        vec_t t[4] = '{
            '{1'b1, 4'd0, 3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 33, 32},
            '{1'b1, 4'd0, 3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 32},
            '{1'b1, 4'd0, 3'd3, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1'b0, 33, 32},
            '{1'b1, 4'd0, 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 32}};
        logic [31:0] res; logic z; int lat, bc;
        foreach (t[i]) begin
            run_op(t[i].m, t[i].c, t[i].f, t[i].a, t[i].b, res, z, lat, bc);
            n_cmp++; if (res !== t[i].r) begin n_bad++; $display("FAIL mul[%0d] result: got %h want %h", i, res, t[i].r); end
            n_cmp++; if (z !== t[i].z) begin n_bad++; $display("FAIL mul[%0d] zero: got %b want %b", i, z, t[i].z); end
            n_cmp++; if (lat != t[i].lat) begin n_bad++; $display("FAIL mul[%0d] latency: got %0d want %0d", i, lat, t[i].lat); end
            n_cmp++; if (bc != t[i].bc) begin n_bad++; $display("FAIL mul[%0d] busy cycles: got %0d want %0d", i, bc, t[i].bc); end
        end
    endtask

    task automatic test_div;
        vec_t t[4] = '{
            '{1'b1, 4'd0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, 32},
            '{1'b1, 4'd0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 32},
            '{1'b1, 4'd0, 3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 33, 32},
            '{1'b1, 4'd0, 3'd7, 32'd100, 32'd7, 32'd2, 1'b0, 33, 32}};
        logic [31:0] res; logic z; int lat, bc;
        foreach (t[i]) begin
            run_op(t[i].m, t[i].c, t[i].f, t[i].a, t[i].b, res, z, lat, bc);
            n_cmp++; if (res !== t[i].r) begin n_bad++; $display("FAIL div[%0d] result: got %h want %h", i, res, t[i].r); end
            n_cmp++; if (z !== t[i].z) begin n_bad++; $display("FAIL div[%0d] zero: got %b want %b", i, z, t[i].z); end
            n_cmp++; if (lat != t[i].lat) begin n_bad++; $display("FAIL div[%0d] latency: got %0d want %0d", i, lat, t[i].lat); end
            n_cmp++; if (bc != t[i].bc) begin n_bad++; $display("FAIL div[%0d] busy cycles: got %0d want %0d", i, bc, t[i].bc); end
        end
    endtask

    task automatic test_fast_path;
        vec_t t[4] = '{
            '{1'b1, 4'd0, 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 0},
            '{1'b1, 4'd0, 3'd6, 32'd5, 32'd0, 32'd5, 1'b0, 1, 0},
            '{1'b1, 4'd0, 3'd4, MIN, 32'hFFFF_FFFF, MIN, 1'b0, 1, 0},
            '{1'b1, 4'd0, 3'd6, MIN, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 0}};
        logic [31:0] res; logic z; int lat, bc;
        foreach (t[i]) begin
            run_op(t[i].m, t[i].c, t[i].f, t[i].a, t[i].b, res, z, lat, bc);
            n_cmp++; if (res !== t[i].r) begin n_bad++; $display("FAIL fast[%0d] result: got %h want %h", i, res, t[i].r); end
            n_cmp++; if (lat != t[i].lat) begin n_bad++; $display("FAIL fast[%0d] latency: got %0d want %0d", i, lat, t[i].lat); end
            n_cmp++; if (bc != t[i].bc) begin n_bad++; $display("FAIL fast[%0d] busy cycles: got %0d want %0d", i, bc, t[i].bc); end
        end
    endtask

    task automatic test_random;
        logic [31:0] res, a, b; logic z, m; logic [3:0] c; logic [2:0] f; int lat, bc;
        for (int i = 0; i < 120; i++) begin
            m = 1'($urandom_range(0, 1));
            c = 4'($urandom_range(0, 15));
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(m, c, f, a, b, res, z, lat, bc);
            n_cmp++; if (res !== ref_res(m, c, f, a, b)) begin n_bad++;
                $display("FAIL rand[%0d] result m=%b c=%h f=%0d a=%h b=%h: got %h want %h", i, m, c, f, a, b, res, ref_res(m, c, f, a, b)); end
            n_cmp++; if (z !== ref_zero(m, f, ref_res(m, c, f, a, b))) begin n_bad++;
                $display("FAIL rand[%0d] zero: got %b want %b", i, z, ref_zero(m, f, ref_res(m, c, f, a, b))); end
            n_cmp++; if (lat != ref_lat(m, f, a, b)) begin n_bad++;
                $display("FAIL rand[%0d] latency: got %0d want %0d", i, lat, ref_lat(m, f, a, b)); end
        end
    endtask

    task automatic test_back_to_back;
        int first_done = 0;
        bus.m_op = 1'b1; bus.alu_ctrl = 4'd0; bus.funct3 = 3'd0; bus.a = 32'hFFFF_FFFF; bus.b = 32'd2; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 40 && first_done == 0; c++) begin
            @(negedge clk);
            if (c == 4) begin
                bus.m_op = 1'b0; bus.a = 32'd1; bus.b = 32'd1; bus.start = 1'b1;
            end
            if (c == 5) bus.start = 1'b0;
            if (bus.done) first_done = c;
        end
        n_cmp++; if (first_done != 33) begin n_bad++; $display("FAIL b2b mul done cycle: got %0d want 33", first_done); end
        n_cmp++; if (bus.result !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL b2b mul result: got %h want fffffffe", bus.result); end
        bus.m_op = 1'b0; bus.alu_ctrl = 4'd0; bus.funct3 = 3'd0; bus.a = 32'd20; bus.b = 32'd22; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL b2b add done: got %b want 1", bus.done); end
        n_cmp++; if (bus.result !== 32'd42) begin n_bad++; $display("FAIL b2b add result: got %h want 0000002a", bus.result); end
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL b2b done pulse width: got %b want 0", bus.done); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort;
        logic [31:0] res; logic z; int lat, bc, dones = 0;
        run_op(1'b0, 4'd0, 3'd0, 32'd1, 32'd1, res, z, lat, bc);
        n_cmp++; if (res !== 32'd2) begin n_bad++; $display("FAIL abort pre-op result: got %h want 2", res); end
        bus.m_op = 1'b1; bus.funct3 = 3'd4; bus.a = 32'd1000; bus.b = 32'd7; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL abort ready: got %b want 1", bus.ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.result !== 32'd0) begin n_bad++; $display("FAIL abort result: got %h want 0", bus.result); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL abort done: got %b want 0", bus.done); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL abort stray done pulses: got %0d want 0", dones); end
        @(posedge clk);
        #1;
        run_op(1'b1, 4'd0, 3'd5, 32'd9, 32'd3, res, z, lat, bc);
        n_cmp++; if (res !== 32'd3) begin n_bad++; $display("FAIL abort divu result: got %h want 3", res); end
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL abort divu latency: got %0d want 33", lat); end
    endtask

    initial begin
        bus.start = 1'b0; bus.m_op = 1'b0; bus.alu_ctrl = 4'd0; bus.funct3 = 3'd0; bus.a = '0; bus.b = '0;
        test_reset();
        test_base();
        test_mul();
        test_div();
        test_fast_path();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
